if_id_stage: RTL
================

# if_id_stage

Fetch-to-decode pipeline register of the RISC pipeline. Takes 16-bit words from instruction memory and assembles one- and two-word instructions. Presents decoded register fields, the immediate and the PC to the decode stage. Its rsrc/rdst outputs are the current-instruction addresses the hazard detection unit compares. It honours that unit's freeze and the branch flush from execute.

## Interface
- PC_WIDTH, 32, width of instruction addresses
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- freeze_pc  in  1  stall from hazard detection unit; holds this stage
- flush  in  1  taken branch/jump; discards stage contents
- mem_valid  in  1  instr_word is valid this cycle
- instr_word  in  16  word from instruction memory
- pc_in  in  PC_WIDTH  address of instr_word
- id_valid  out  1  outputs carry a real instruction
- id_opcode  out  5  instr[15:11]
- id_rsrc  out  3  instr[10:8]
- id_rdst  out  3  instr[7:5]
- id_imm  out  16  second word of two-word instruction, else 0
- id_pc  out  PC_WIDTH  address of first word of instruction
- id_busy  out  1  stage in SECOND, waiting for immediate word

## Operation
- Encoding: instr[0]=1 marks the first word of a two-word instruction; instr[4:1] are reserved and ignored.
- States: FIRST (expects header word), SECOND (header held, expects immediate).
- Internal holding registers: hold_opcode, hold_rsrc, hold_rdst, hold_pc.
- Priority per cycle: rst > flush > freeze_pc > normal.
- rst: state=FIRST, holding registers cleared, all outputs 0.
- flush: state=FIRST, holding registers cleared, id_valid=0, all id_* fields 0 (NOP bubble, opcode 5'b00000).
- freeze_pc (no flush): state, holding registers and all outputs unchanged; instr_word ignored, because the PC is also frozen and re-presents the same word.
- FIRST, mem_valid=0: bubble; id_valid=0, fields 0.
- FIRST, mem_valid=1, instr[0]=0: register fields, id_imm=0, id_pc=pc_in, id_valid=1; stay FIRST.
- FIRST, mem_valid=1, instr[0]=1: capture header into holding registers; bubble out (id_valid=0, fields 0); go SECOND.
- SECOND, mem_valid=0: bubble; stay SECOND; holding registers kept.
- SECOND, mem_valid=1: output holding fields, id_imm=instr_word, id_pc=hold_pc, id_valid=1; go FIRST. instr[0] of the immediate word is data and is never decoded.
- Bubbles always drive id_opcode/id_rsrc/id_rdst/id_imm/id_pc to 0, so the hazard unit never compares stale addresses.
- id_busy = (state==SECOND), registered.

## Timing
- All outputs registered; reset value 0 for every output.
- One-word instruction: word at edge N -> id_valid at N+1; latency 1 cycle.
- Two-word: header at N, immediate at N+1 -> bubble after N, instruction after N+1; latency 2 cycles from header, with one bubble.
- freeze_pc asserted k cycles -> outputs frozen for exactly k cycles. The next accepted word is the one present in the first cycle after freeze_pc drops.
- flush asserted in SECOND -> the partial header is lost, with no issue. The next cycle starts in FIRST.
- flush and freeze_pc together -> flush wins and the stage bubbles.
- rst mid-instruction (SECOND) -> FIRST and zeros at the next edge; any partial instruction is lost.

## Test plan
- Reset: rst=1 two cycles with mem_valid=1, instr=16'hFFFF -> all outputs 0, id_busy=0. Release rst and send instr=16'h9240, pc=0x10 -> next cycle opcode=5'b10010, rsrc=2, rdst=2, imm=0, pc=0x10, valid=1.
- Two-word: instr=16'h8921 @pc 0x20, then 16'hBEEF @pc 0x21 -> first cycle valid=0, busy=1. Second cycle opcode=5'b10001, rsrc=1, rdst=1, imm=16'hBEEF, pc=0x20, valid=1, busy=0.
- Freeze: issue 16'h7A60, then freeze_pc=1 for 3 cycles while instr changes to 16'h0000 -> outputs stay opcode=5'b01111, rsrc=2, rdst=3, valid=1 for all 3 cycles.
- Flush in SECOND: header 16'h8921, then flush=1 with instr 16'h1234 -> valid=0, all fields 0, busy=0. Next word 16'h0840 decodes as one-word opcode=1, rsrc=0, rdst=2.
- Simultaneous flush+freeze in FIRST with valid output held -> next cycle valid=0, fields 0.
- mem_valid gap in SECOND: header, then 2 cycles mem_valid=0, then imm 16'h00AA -> busy=1 held 3 cycles, then valid=1 with imm=16'h00AA and pc of the header.

Source files
------------

// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline register.
// Assembles one- and two-word instructions from 16-bit fetch words.
module if_id_stage #(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze_pc,
    input  logic                flush,
    input  logic                mem_valid,
    input  logic [15:0]         instr_word,
    input  logic [PC_WIDTH-1:0] pc_in,
    output logic                id_valid,
    output logic [4:0]          id_opcode,
    output logic [2:0]          id_rsrc,
    output logic [2:0]          id_rdst,
    output logic [15:0]         id_imm,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic                id_busy
);

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } stateT;

    stateT state, stateNext;

    logic [4:0]          holdOpcode, holdOpcodeNext;
    logic [2:0]          holdRsrc, holdRsrcNext;
    logic [2:0]          holdRdst, holdRdstNext;
    logic [PC_WIDTH-1:0] holdPc, holdPcNext;

    logic                validNext;
    logic [4:0]          opcodeNext;
    logic [2:0]          rsrcNext;
    logic [2:0]          rdstNext;
    logic [15:0]         immNext;
    logic [PC_WIDTH-1:0] pcNext;

    logic twoWord;
    assign twoWord = instr_word[0];

    // Next-state, holding and output selection; freeze keeps everything as is.
    always_comb begin
        stateNext      = state;
        holdOpcodeNext = holdOpcode;
        holdRsrcNext   = holdRsrc;
        holdRdstNext   = holdRdst;
        holdPcNext     = holdPc;
        validNext      = id_valid;
        opcodeNext     = id_opcode;
        rsrcNext       = id_rsrc;
        rdstNext       = id_rdst;
        immNext        = id_imm;
        pcNext         = id_pc;

        if (flush) begin
            stateNext      = FIRST;
            holdOpcodeNext = '0;
            holdRsrcNext   = '0;
            holdRdstNext   = '0;
            holdPcNext     = '0;
            validNext      = 1'b0;
            opcodeNext     = '0;
            rsrcNext       = '0;
            rdstNext       = '0;
            immNext        = '0;
            pcNext         = '0;
        end else if (!freeze_pc) begin
            // Bubble unless an instruction completes this cycle.
            validNext  = 1'b0;
            opcodeNext = '0;
            rsrcNext   = '0;
            rdstNext   = '0;
            immNext    = '0;
            pcNext     = '0;
            unique case (state)
                FIRST: begin
                    if (mem_valid && !twoWord) begin
                        validNext  = 1'b1;
                        opcodeNext = instr_word[15:11];
                        rsrcNext   = instr_word[10:8];
                        rdstNext   = instr_word[7:5];
                        pcNext     = pc_in;
                    end else if (mem_valid) begin
                        holdOpcodeNext = instr_word[15:11];
                        holdRsrcNext   = instr_word[10:8];
                        holdRdstNext   = instr_word[7:5];
                        holdPcNext     = pc_in;
                        stateNext      = SECOND;
                    end
                end
                SECOND: begin
                    if (mem_valid) begin
                        validNext  = 1'b1;
                        opcodeNext = holdOpcode;
                        rsrcNext   = holdRsrc;
                        rdstNext   = holdRdst;
                        immNext    = instr_word;
                        pcNext     = holdPc;
                        stateNext  = FIRST;
                    end
                end
                default: stateNext = FIRST;
            endcase
        end
    end

    // Register state, holding fields and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FIRST;
            holdOpcode <= '0;
            holdRsrc   <= '0;
            holdRdst   <= '0;
            holdPc     <= '0;
            id_valid   <= 1'b0;
            id_opcode  <= '0;
            id_rsrc    <= '0;
            id_rdst    <= '0;
            id_imm     <= '0;
            id_pc      <= '0;
            id_busy    <= 1'b0;
        end else begin
            state      <= stateNext;
            holdOpcode <= holdOpcodeNext;
            holdRsrc   <= holdRsrcNext;
            holdRdst   <= holdRdstNext;
            holdPc     <= holdPcNext;
            id_valid   <= validNext;
            id_opcode  <= opcodeNext;
            id_rsrc    <= rsrcNext;
            id_rdst    <= rdstNext;
            id_imm     <= immNext;
            id_pc      <= pcNext;
            id_busy    <= (stateNext == SECOND);
        end
    end

endmodule
